// File: rtl/alu_operand_sched.sv
`default_nettype none
// ============================================================================
// Module      : alu_operand_sched
// Description : Decode-to-execute scheduler for the execute-stage ALU.
//               Tracks the destinations of the two instructions ahead of
//               decode (E and M slots), issues registered forwarding selects,
//               raises the load-use stall and sequences the RTI flag restore.
//               Optional feature macro: ALU_FWD_EN (forwarding network).
//               Without it, selects stay on the register file and every RAW
//               match against E or M stalls decode.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_operand_sched #(
    parameter int REG_AW      = 3,
    parameter int POP_TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic              id_use_rs1,
    input  logic              id_use_rs2,
    input  logic              id_use_imm,
    input  logic [REG_AW-1:0] id_rd,
    input  logic              id_wr_en,
    input  logic [1:0]        id_kind,
    input  logic              id_rti,
    input  logic              pop_done,
    input  logic              flush,
    output logic              stall,
    output logic [2:0]        alu_src1_select,
    output logic [2:0]        alu_src2_select,
    output logic              alu_src_select,
    output logic              flag_regsel,
    output logic              flagreg_enable,
    output logic              restore_err
);

    localparam int               CNT_W    = $clog2(POP_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(POP_TIMEOUT - 1);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_WAIT    = 2'd1;
    localparam logic [1:0] ST_RESTORE = 2'd2;

    localparam logic [2:0] SEL_WB    = 3'b000;
    localparam logic [2:0] SEL_EX    = 3'b001;
    localparam logic [2:0] SEL_RF    = 3'b010;
    localparam logic [2:0] SEL_EXIN  = 3'b011;
    localparam logic [2:0] SEL_MEMIN = 3'b100;

    localparam logic [1:0] K_IN   = 2'b01;
    localparam logic [1:0] K_LOAD = 2'b10;

    // In-flight slots: E is one instruction ahead of decode, M is two ahead
    logic              e_valid_q, e_wr_q, m_valid_q, m_wr_q;
    logic [REG_AW-1:0] e_rd_q, m_rd_q;
    logic [1:0]        e_kind_q, m_kind_q;

    logic [2:0]        sel1_q, sel2_q;
    logic              src_sel_q;

    logic [1:0]        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              err_q, err_d;

    logic              w_e_hit1, w_e_hit2, w_m_hit1, w_m_hit2;
    logic [3:0]        w_op1, w_op2;     // {hazard, select}
    logic              w_hazard, w_busy, w_issue;

    assign w_e_hit1 = e_valid_q & e_wr_q & (e_rd_q == id_rs1);
    assign w_e_hit2 = e_valid_q & e_wr_q & (e_rd_q == id_rs2);
    assign w_m_hit1 = m_valid_q & m_wr_q & (m_rd_q == id_rs1);
    assign w_m_hit2 = m_valid_q & m_wr_q & (m_rd_q == id_rs2);

`ifdef ALU_FWD_EN
    // Nearest producer wins; a load still in E cannot be forwarded yet
    function automatic logic [3:0] fwd_resolve(input logic       e_hit,
                                               input logic [1:0] e_kind,
                                               input logic       m_hit,
                                               input logic [1:0] m_kind);
        logic [3:0] r;
        r = {1'b0, SEL_RF};
        if (e_hit) begin
            if (e_kind == K_LOAD)    r = {1'b1, SEL_RF};
            else if (e_kind == K_IN) r = {1'b0, SEL_EXIN};
            else                     r = {1'b0, SEL_EX};
        end else if (m_hit) begin
            if (m_kind == K_IN)      r = {1'b0, SEL_MEMIN};
            else                     r = {1'b0, SEL_WB};
        end
        return r;
    endfunction

    // Operand resolution with forwarding; an immediate operand 2 never hazards
    always_comb begin
        w_op1 = {1'b0, SEL_RF};
        w_op2 = {1'b0, SEL_RF};
        if (id_use_rs1)
            w_op1 = fwd_resolve(w_e_hit1, e_kind_q, w_m_hit1, m_kind_q);
        if (id_use_rs2 && !id_use_imm)
            w_op2 = fwd_resolve(w_e_hit2, e_kind_q, w_m_hit2, m_kind_q);
    end
`else
    logic w_unused_kind;
    assign w_unused_kind = ^{e_kind_q, m_kind_q};

    // Operand resolution without forwarding: any RAW match in flight stalls
    always_comb begin
        w_op1 = {1'b0, SEL_RF};
        w_op2 = {1'b0, SEL_RF};
        if (id_use_rs1)
            w_op1 = {(w_e_hit1 | w_m_hit1), SEL_RF};
        if (id_use_rs2 && !id_use_imm)
            w_op2 = {(w_e_hit2 | w_m_hit2), SEL_RF};
    end
`endif

    assign w_hazard = w_op1[3] | w_op2[3];
    assign w_busy   = (state_q != ST_IDLE);
    assign stall    = id_valid & ~flush & (w_hazard | w_busy);
    assign w_issue  = id_valid & ~stall & ~flush;

    // Slot advance: issued instruction enters E, stall/flush injects a bubble
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            e_valid_q <= 1'b0;
            e_wr_q    <= 1'b0;
            e_rd_q    <= '0;
            e_kind_q  <= '0;
            m_valid_q <= 1'b0;
            m_wr_q    <= 1'b0;
            m_rd_q    <= '0;
            m_kind_q  <= '0;
        end else begin
            e_valid_q <= w_issue;
            e_wr_q    <= w_issue & id_wr_en;
            e_rd_q    <= id_rd;
            e_kind_q  <= id_kind;
            m_valid_q <= e_valid_q & ~flush;
            m_wr_q    <= e_wr_q & ~flush;
            m_rd_q    <= e_rd_q;
            m_kind_q  <= e_kind_q;
        end
    end

    // Selects are registered so they line up with the EX cycle of the issue
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sel1_q    <= SEL_RF;
            sel2_q    <= SEL_RF;
            src_sel_q <= 1'b0;
        end else begin
            sel1_q    <= w_issue ? w_op1[2:0] : SEL_RF;
            sel2_q    <= w_issue ? w_op2[2:0] : SEL_RF;
            src_sel_q <= w_issue & id_use_imm;
        end
    end

    assign alu_src1_select = sel1_q;
    assign alu_src2_select = sel2_q;
    assign alu_src_select  = src_sel_q;

    // Flag FSM state register, wait counter and error pulse
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    // Flag FSM next state: RTI issue arms the wait, pop_done beats the timeout
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        err_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (w_issue && id_rti) begin
                    state_d = ST_WAIT;
                    cnt_d   = '0;
                end
            end
            ST_WAIT: begin
                if (pop_done) begin
                    state_d = ST_RESTORE;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = ST_IDLE;
                    err_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_RESTORE: state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
    end

    // Flag FSM outputs: restore strobes only in the RESTORE cycle
    always_comb begin
        flag_regsel    = (state_q == ST_RESTORE);
        flagreg_enable = (state_q == ST_RESTORE);
    end

    assign restore_err = err_q;

endmodule
`default_nettype wire
